calc_display_driver: RTL
========================

// Module: calc_display_driver
// PURPOSE
//  Downstream stage of the calculator accumulator: consumes its 8-bit result bus.
//  Converts it to 3 BCD digits with a serial double-dabble engine.
//  Drives a 3-digit time-multiplexed 7-segment display.
//  Sits between the accumulator output and the chip output pins.
// PARAMETERS
//  REFRESH_DIV  1024  clk cycles per digit slot; legal >=2
//  CNT_W        $clog2(REFRESH_DIV)  prescaler width (derived, do not override)
// PORTS
//  clk       in   1   system clock, all state on posedge
//  rst_n     in   1   asynchronous active-low reset
//  value_in  in   8   unsigned accumulator result, may change any cycle
//  seg       out  7   segments {g,f,e,d,c,b,a}, active-high
//  dig_sel   out  3   one-hot digit enable, active-high; [0]=ones [1]=tens [2]=hundreds
//  busy      out  1   high while a conversion is in flight
//  bcd_out   out  12  committed digits {hund,tens,ones}, for test/debug
// BEHAVIOUR
//  Reset (async assert, sync-to-clk release):
//  - FSM=IDLE, src_q=0, bcd_out=12'h000, prescaler=0, digit idx=0.
//  - Result: busy=0, dig_sel=3'b001, seg=7'h3F (digit "0").
//  Conversion FSM, states IDLE -> SHIFT -> COMMIT -> IDLE:
//  - IDLE: edge where value_in != src_q: src_q<=value_in, shift reg<=value_in,
//    BCD scratch<=0, bit cnt<=0, go SHIFT. Otherwise stay.
//  - SHIFT: one bit per edge; each BCD nibble >=5 gets +3, then left-shift
//    {scratch,shift}. cnt increments; after the 8th shift go COMMIT.
//  - COMMIT: bcd_out<=scratch, go IDLE.
//  - busy=1 in SHIFT and COMMIT; busy=0 in IDLE.
//  - Latency: value_in change sampled at edge E; bcd_out updates at edge E+9.
//  - value_in changes during SHIFT/COMMIT are ignored. IDLE re-compares on
//    return, so only the latest value is ever converted (no queue).
//  - Scratch is 10 bits internally. Max input 255 gives hundreds <=2; no overflow.
//  - Reset mid-conversion: abort, bcd_out=0, FSM=IDLE. If value_in!=0 after
//    release, a fresh conversion starts on the first edge.
//  Scan:
//  - Prescaler counts 0..REFRESH_DIV-1 and wraps.
//  - On wrap, idx advances 0->1->2->0. idx==3 is unreachable; force it to 0.
//  - dig_sel = one-hot(idx), combinational from idx.
//  - seg = 7-seg decode of the bcd_out nibble chosen by idx, combinational.
//  - Scan runs independently of the FSM. A commit mid-slot shows the new digit
//    immediately.
//  - Decode table: 0..9 standard; nibble >9 is unreachable, decode to 7'h00.
// CONFIGURATION
//  `define CALC_DISP_LZ_BLANK_EN  Leading-zero blanking.
//  - Defined: hundreds blank when it is 0; tens blank when hundreds and tens
//    are both 0; ones never blanked.
//  - Blank = seg 7'h00 with dig_sel still asserted (slot timing unchanged).
//  - Undefined: all three digits are always lit; 7 shows "007".
// STRUCTURE
//  calc_display_pkg:
//  - disp_state_t enum {IDLE,SHIFT,COMMIT}
//  - NUM_DIGITS=3
//  - SEG_LUT[0:9] constant array
//  - function seg_decode(logic[3:0])
//  Sub-module bin2bcd_serial (FSM + shift datapath):
//  - in: clk, rst_n, start, bin[7:0]
//  - out: busy, done, bcd[11:0]
//  Top holds src_q, bcd_out, prescaler, idx and the output mux/decode.
// TESTING  (REFRESH_DIV=4 for sim)
//  1 reset then idle: busy=0, bcd_out=000, dig_sel cycles 001->010->100->001 every 4 clks,
//    seg=3F in every slot (LZ_BLANK_EN: 00,00,3F).
//  2 value_in=8'd123 held: busy rises next edge; bcd_out=12'h123 exactly 9 edges after
//    sampling; slots show seg 06/5B/4F on dig_sel 100/010/001.
//  3 value_in=255 -> bcd_out=12'h255; value_in=0 -> 12'h000; value_in=10 -> 12'h010
//    (LZ_BLANK_EN: hundreds slot seg=00, tens slot seg=06).
//  4 value_in 8'd42 then 8'd99 at edge 3 of conversion: commit shows 042, then a second
//    conversion starts immediately and ends at 099; no intermediate value is displayed.
//  5 rst_n low mid-SHIFT (value 200): busy=0, bcd_out=000 asynchronously; after release
//    200 converts from scratch to 12'h200.
//  6 value_in toggles 5->5 (no change): FSM stays IDLE, busy never asserts.

Source files
------------

// File: rtl/calc_display_pkg.sv
// ---------------------------------------------------------------------------
// calc_display_pkg
//   Shared types and constants for the calculator display driver:
//   conversion FSM state enum, digit count, 7-segment lookup table and the
//   nibble-to-segment decode helper.
//   Segment encoding is {g,f,e,d,c,b,a}, active-high.
// ---------------------------------------------------------------------------
package calc_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } disp_state_t;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Non-decimal nibbles cannot come out of the converter; show them dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'h00;
        for (int i = 0; i < 10; i++) begin
            if (nib == 4'(i)) s = SEG_LUT[i];
        end
        return s;
    endfunction

endpackage

// File: rtl/calc_display_driver_bin2bcd.sv
// ---------------------------------------------------------------------------
// bin2bcd_serial
//   Serial double-dabble converter, one input bit per clock.
//   IDLE -> SHIFT (8 edges) -> COMMIT -> IDLE.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   start  in   load bin and begin a conversion (honoured in IDLE only)
//   bin    in   8-bit unsigned value to convert
//   busy   out  high in SHIFT and COMMIT
//   done   out  high during COMMIT; bcd is final in that cycle
//   bcd    out  {hund,tens,ones} from the scratch register
// ---------------------------------------------------------------------------
module bin2bcd_serial
    import calc_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    disp_state_t state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [9:0]  scratch_q, scratch_d;   // {hund[1:0], tens[3:0], ones[3:0]}
    logic [2:0]  cnt_q, cnt_d;

    logic [3:0]  ones_adj, tens_adj;
    logic [8:0]  adj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
        end
    end

    // Add-3 correction. Hundreds never exceeds 2 for an 8-bit input, so it
    // needs no correction, and its top bit is always 0 before a shift; only
    // the low 9 bits of the corrected scratch are carried into the shift.
    always_comb begin
        ones_adj = (scratch_q[3:0] >= 4'd5) ? scratch_q[3:0] + 4'd3 : scratch_q[3:0];
        tens_adj = (scratch_q[7:4] >= 4'd5) ? scratch_q[7:4] + 4'd3 : scratch_q[7:4];
        adj      = {scratch_q[8], tens_adj, ones_adj};
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, shift_d} = {adj, shift_q, 1'b0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = COMMIT;
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == COMMIT);
    assign bcd  = {2'b00, scratch_q};

endmodule

// File: rtl/calc_display_driver.sv
// ---------------------------------------------------------------------------
// calc_display_driver
//   Takes the accumulator's 8-bit result, converts it to 3 BCD digits with a
//   serial double-dabble engine and drives a 3-digit multiplexed 7-segment
//   display. Only the latest input value is converted; changes during a
//   conversion are picked up when the engine returns to idle.
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>=2)
//   CNT_W        prescaler width, derived; do not override
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   value_in  in   8-bit unsigned accumulator result
//   seg       out  segments {g,f,e,d,c,b,a}, active-high
//   dig_sel   out  one-hot digit enable; [0]=ones [1]=tens [2]=hundreds
//   busy      out  conversion in flight
//   bcd_out   out  committed digits {hund,tens,ones}
// Configuration:
//   CALC_DISP_LZ_BLANK_EN  when defined, blanks leading zeros (hundreds when
//   0, tens when hundreds and tens are 0); slot timing is unchanged.
// ---------------------------------------------------------------------------
module calc_display_driver
    import calc_display_pkg::*;
#(
    parameter int REFRESH_DIV = 1024,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  value_in,
    output logic [6:0]  seg,
    output logic [2:0]  dig_sel,
    output logic        busy,
    output logic [11:0] bcd_out
);

    logic [7:0]       src_q, src_d;
    logic [11:0]      bcd_out_q, bcd_out_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [1:0]       idx_q, idx_d;

    logic             conv_start, conv_busy, conv_done;
    logic [11:0]      conv_bcd;

    logic [3:0]       nib;
    logic [6:0]       seg_raw;

    // Busy covers COMMIT, so the compare only happens once the engine is
    // back in IDLE; that is what lets a mid-conversion change be seen later.
    assign conv_start = !conv_busy && (value_in != src_q);

    bin2bcd_serial u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (value_in),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        src_d     = conv_start ? value_in : src_q;
        bcd_out_d = conv_done  ? conv_bcd : bcd_out_q;
    end

    // Scan prescaler and digit index.
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == CNT_W'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            case (idx_q)
                2'd0:    idx_d = 2'd1;
                2'd1:    idx_d = 2'd2;
                default: idx_d = 2'd0;
            endcase
        end
        if (idx_q == 2'd3) idx_d = 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= '0;
            bcd_out_q <= '0;
            presc_q   <= '0;
            idx_q     <= '0;
        end else begin
            src_q     <= src_d;
            bcd_out_q <= bcd_out_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
        end
    end

    // Digit select and segment mux; the unreachable idx 3 shows as ones.
    always_comb begin
        case (idx_q)
            2'd1: begin dig_sel = 3'b010; nib = bcd_out_q[7:4];  end
            2'd2: begin dig_sel = 3'b100; nib = bcd_out_q[11:8]; end
            default: begin dig_sel = 3'b001; nib = bcd_out_q[3:0]; end
        endcase
        seg_raw = seg_decode(nib);
    end

`ifdef CALC_DISP_LZ_BLANK_EN
    always_comb begin
        seg = seg_raw;
        if (idx_q == 2'd2 && bcd_out_q[11:8] == 4'd0) seg = 7'h00;
        if (idx_q == 2'd1 && bcd_out_q[11:4] == 8'd0) seg = 7'h00;
    end
`else
    assign seg = seg_raw;
`endif

    assign busy    = conv_busy;
    assign bcd_out = bcd_out_q;

endmodule
